// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Requester-side bundle of the data-memory arbiter (one per master).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one BRAM port between two masters, one access in flight.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int FIXED_PRIO = 0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    dmem_arbiter_if.slave          m0,
    dmem_arbiter_if.slave          m1,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   mem_we,
    input  wire logic [DATA_W-1:0] mem_rdata,
    output logic                   busy
);
    localparam int              CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] c_LAT = CNT_W'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_m1;
    logic              r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_any;
    logic              w_pick_m1;
    logic              w_issue;
    logic              w_rd_done;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_any        = m0.req | m1.req;
        w_pick_m1    = 1'b0;
        w_state_next = r_state;
        // Tie-break: fixed mode favours m0, otherwise whoever was not granted last.
        if (m1.req && !m0.req) begin
            w_pick_m1 = 1'b1;
        end else if (m0.req && m1.req && (FIXED_PRIO == 0)) begin
            w_pick_m1 = ~r_last_m1;
        end
        w_win_we    = w_pick_m1 ? m1.we    : m0.we;
        w_win_addr  = w_pick_m1 ? m1.addr  : m0.addr;
        w_win_wdata = w_pick_m1 ? m1.wdata : m0.wdata;
        w_issue     = (r_state == S_IDLE) && w_any;
        w_rd_done   = (r_state == S_RD) && (r_cnt == c_LAT);

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = w_win_we ? S_WR : S_RD;
                end
            end
            S_WR: begin
                w_state_next = S_IDLE;
            end
            S_RD: begin
                if (w_rd_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_m1   <= 1'b1;
            r_owner     <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_mem_we  <= 1'b0;

            if (w_issue) begin
                r_mem_addr  <= w_win_addr;
                r_mem_wdata <= w_win_wdata;
                r_mem_we    <= w_win_we;
                r_owner     <= w_pick_m1;
                r_last_m1   <= w_pick_m1;
                r_gnt0      <= ~w_pick_m1;
                r_gnt1      <= w_pick_m1;
                r_cnt       <= '0;
            end

            if ((r_state == S_RD) && !w_rd_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Only the owner's read register moves; the other master's data is untouched.
            if (w_rd_done) begin
                if (r_owner) begin
                    r_rdata1  <= mem_rdata;
                    r_rvalid1 <= 1'b1;
                end else begin
                    r_rdata0  <= mem_rdata;
                    r_rvalid0 <= 1'b1;
                end
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign busy      = (r_state != S_IDLE);

    assign m0.gnt    = r_gnt0;
    assign m0.rvalid = r_rvalid0;
    assign m0.rdata  = r_rdata0;
    assign m1.gnt    = r_gnt1;
    assign m1.rvalid = r_rvalid1;
    assign m1.rdata  = r_rdata1;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter (round-robin and fixed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    int          n_cmp  = 0;
    int          n_fail = 0;

    logic [31:0] rr_addr, rr_wdata, rr_rdata, fp_addr, fp_wdata;
    logic        rr_we, rr_busy, fp_we, fp_busy;
    logic [31:0] q1, q2;

    dmem_arbiter_if a0 ();
    dmem_arbiter_if a1 ();
    dmem_arbiter_if f0 ();
    dmem_arbiter_if f1 ();

    always #5 clk = ~clk;

    dmem_arbiter #(.RD_LAT(2), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .m0(a0), .m1(a1),
        .mem_addr(rr_addr), .mem_wdata(rr_wdata), .mem_we(rr_we),
        .mem_rdata(rr_rdata), .busy(rr_busy)
    );

    dmem_arbiter #(.RD_LAT(2), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .m0(f0), .m1(f1),
        .mem_addr(fp_addr), .mem_wdata(fp_wdata), .mem_we(fp_we),
        .mem_rdata(32'h0), .busy(fp_busy)
    );

    // Read-only BRAM contents with a two-cycle read pipeline
    function automatic logic [31:0] bram(input logic [31:0] a);
        return (a == 32'h20) ? 32'h1234_5678 : (32'hA500_0000 | a);
    endfunction

    always @(posedge clk) begin
        q1 <= bram(rr_addr);
        q2 <= q1;
    end
    assign rr_rdata = q2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int g0, g1, both;
        int order[$];
        logic seen;

        rst = 1'b1;
        a0.req = 0; a0.we = 0; a0.addr = 0; a0.wdata = 0;
        a1.req = 0; a1.we = 0; a1.addr = 0; a1.wdata = 0;
        f0.req = 0; f0.we = 0; f0.addr = 0; f0.wdata = 0;
        f1.req = 0; f1.we = 0; f1.addr = 0; f1.wdata = 0;
        tick; tick;
        chk("rst_mem_we", 32'(rr_we), 32'd0);
        chk("rst_busy",   32'(rr_busy), 32'd0);
        chk("rst_addr",   rr_addr, 32'd0);
        chk("rst_gnt",    32'({a0.gnt, a1.gnt}), 32'd0);
        chk("rst_rvalid", 32'({a0.rvalid, a1.rvalid}), 32'd0);
        chk("rst_rdata0", a0.rdata, 32'd0);
        rst = 1'b0;

        // 1: m0 single write
        a0.req = 1; a0.we = 1; a0.addr = 32'h10; a0.wdata = 32'hDEAD_BEEF;
        tick;
        chk("t1_we",    32'(rr_we), 32'd1);
        chk("t1_addr",  rr_addr, 32'h10);
        chk("t1_wdata", rr_wdata, 32'hDEAD_BEEF);
        chk("t1_gnt0",  32'(a0.gnt), 32'd1);
        chk("t1_gnt1",  32'(a1.gnt), 32'd0);
        a0.req = 0;
        tick;
        chk("t1_we_off", 32'(rr_we), 32'd0);
        chk("t1_busy",   32'(rr_busy), 32'd0);
        chk("t1_gnt_off", 32'(a0.gnt), 32'd0);

        // 2: m1 read, rvalid four cycles after the request
        a1.req = 1; a1.we = 0; a1.addr = 32'h20;
        tick;
        chk("t2_gnt1", 32'(a1.gnt), 32'd1);
        chk("t2_addr", rr_addr, 32'h20);
        chk("t2_we",   32'(rr_we), 32'd0);
        a1.req = 0;
        tick;
        chk("t2_rv_c2", 32'(a1.rvalid), 32'd0);
        tick;
        chk("t2_rv_c3", 32'(a1.rvalid), 32'd0);
        chk("t2_busy_c3", 32'(rr_busy), 32'd1);
        tick;
        chk("t2_rv_c4",   32'(a1.rvalid), 32'd1);
        chk("t2_rdata",   a1.rdata, 32'h1234_5678);
        chk("t2_rv0",     32'(a0.rvalid), 32'd0);
        chk("t2_busy_c4", 32'(rr_busy), 32'd0);
        tick;
        chk("t2_rv_c5",   32'(a1.rvalid), 32'd0);
        chk("t2_hold",    a1.rdata, 32'h1234_5678);

        // 3: round-robin with both reading continuously, m0 first after reset
        rst = 1'b1; tick; rst = 1'b0;
        a0.req = 1; a0.we = 0; a0.addr = 32'h30;
        a1.req = 1; a1.we = 0; a1.addr = 32'h40;
        both = 0;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (a0.gnt) order.push_back(0);
            if (a1.gnt) order.push_back(1);
            if (a0.gnt && a1.gnt) both++;
            if (i == 3) begin
                chk("t3_rv0",    32'(a0.rvalid), 32'd1);
                chk("t3_rdata0", a0.rdata, 32'hA500_0030);
            end
            if (i == 7) begin
                chk("t3_rv1",    32'(a1.rvalid), 32'd1);
                chk("t3_rdata1", a1.rdata, 32'hA500_0040);
            end
        end
        a0.req = 0; a1.req = 0;
        chk("t3_ngrants", 32'(order.size()), 32'd4);
        chk("t3_both",    32'(both), 32'd0);
        if (order.size() == 4) begin
            chk("t3_g0", 32'(order[0]), 32'd0);
            chk("t3_g1", 32'(order[1]), 32'd1);
            chk("t3_g2", 32'(order[2]), 32'd0);
            chk("t3_g3", 32'(order[3]), 32'd1);
        end
        tick; tick;

        // 4: fixed priority, both writing with requests held
        f0.req = 1; f0.we = 1; f0.addr = 32'h60; f0.wdata = 32'h6;
        f1.req = 1; f1.we = 1; f1.addr = 32'h70; f1.wdata = 32'h7;
        g0 = 0; g1 = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (f0.gnt) g0++;
            if (f1.gnt) g1++;
        end
        chk("t4_g0", 32'(g0), 32'd5);
        chk("t4_g1", 32'(g1), 32'd0);
        f0.req = 0;
        tick;
        chk("t4_m1_gnt",  32'(f1.gnt), 32'd1);
        chk("t4_m1_addr", fp_addr, 32'h70);
        chk("t4_m1_we",   32'(fp_we), 32'd1);
        f1.req = 0;
        tick;
        chk("t4_idle", 32'(fp_busy), 32'd0);

        // 5: reset in the middle of a read discards it
        a1.req = 1; a1.we = 0; a1.addr = 32'h50;
        tick;
        chk("t5_gnt1", 32'(a1.gnt), 32'd1);
        a1.req = 0;
        tick;
        #2 rst = 1'b1;
        #1;
        chk("t5_busy",  32'(rr_busy), 32'd0);
        chk("t5_addr",  rr_addr, 32'd0);
        chk("t5_rdata", a1.rdata, 32'd0);
        chk("t5_outs",  32'({rr_we, a0.gnt, a1.gnt, a0.rvalid, a1.rvalid}), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (a1.rvalid || a0.rvalid) seen = 1'b1;
        end
        chk("t5_no_rvalid", 32'(seen), 32'd0);
        a0.req = 1; a0.we = 0; a0.addr = 32'h05;
        tick;
        chk("t5_new_gnt",  32'(a0.gnt), 32'd1);
        chk("t5_new_addr", rr_addr, 32'h05);
        a0.req = 0;
        tick; tick; tick;
        chk("t5_new_rv",    32'(a0.rvalid), 32'd1);
        chk("t5_new_rdata", a0.rdata, 32'hA500_0005);
        tick;

        // 6: m0 back-to-back writes with request held high
        a0.req = 1; a0.we = 1; a0.addr = 32'h0; a0.wdata = 32'h100;
        for (int w = 0; w < 4; w++) begin
            tick;
            chk("t6_we",    32'(rr_we), 32'd1);
            chk("t6_addr",  rr_addr, 32'(w));
            chk("t6_wdata", rr_wdata, 32'h100 + 32'(w));
            chk("t6_gnt",   32'(a0.gnt), 32'd1);
            if (w < 3) begin
                a0.addr = 32'(w + 1); a0.wdata = 32'h100 + 32'(w + 1);
            end else begin
                a0.req = 0;
            end
            tick;
            chk("t6_we_gap",  32'(rr_we), 32'd0);
            chk("t6_gnt_gap", 32'(a0.gnt), 32'd0);
        end
        tick;
        chk("t6_end_busy", 32'(rr_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
